// File: rtl/da2_sample_streamer_if.sv
// da2_sample_streamer_if: AXI-Lite write-only bus between the sample streamer and the Pmod DA2 slave
//   master modport: drives aw/w channels and bready; receives ready signals and the write response
//   slave modport : the mirror view for the DA2 slave (or a bench model of it)
interface da2_sample_streamer_if #(
  parameter int ADDR_WIDTH = 4
) ();
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  awready, wready, bresp, bvalid
  );
  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/da2_sample_streamer.sv
// da2_sample_streamer: buffers AXI-Stream sample pairs and writes them to the DA2 CH0/CH1 registers at a programmable rate
//   s_axi_aclk/s_axi_aresetn : clock, asynchronous active-low reset
//   enable/period            : sample tick every period+1 clocks while enable=1
//   clear_flags              : one-cycle pulse clearing the sticky flags
//   s_axis_*                 : sample pairs in, tdata[11:0]=CH0, tdata[27:16]=CH1
//   m_axi                    : AXI-Lite write master towards the DA2 slave
//   fifo_level               : stored sample pairs
//   underrun/overrun/resp_err: sticky status flags
module da2_sample_streamer #(
  parameter int FIFO_DEPTH         = 16,
  parameter int DUAL_MODE          = 1,
  parameter int DIV_WIDTH          = 16,
  parameter int OFFSET_CH0         = 0,
  parameter int OFFSET_CH1         = 4,
  parameter int C_M_AXI_ADDR_WIDTH = 4
) (
  input  logic                         s_axi_aclk,
  input  logic                         s_axi_aresetn,
  input  logic                         enable,
  input  logic [DIV_WIDTH-1:0]         period,
  input  logic                         clear_flags,
  input  logic [31:0]                  s_axis_tdata,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  da2_sample_streamer_if.master        m_axi,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output logic                         underrun,
  output logic                         overrun,
  output logic                         resp_err
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL = LW'(FIFO_DEPTH);
  localparam logic [C_M_AXI_ADDR_WIDTH-1:0] ADDR_CH0 = C_M_AXI_ADDR_WIDTH'(OFFSET_CH0);
  localparam logic [C_M_AXI_ADDR_WIDTH-1:0] ADDR_CH1 = C_M_AXI_ADDR_WIDTH'(OFFSET_CH1);
  typedef enum logic [2:0] {IDLE, WR_CH0, RESP_CH0, WR_CH1, RESP_CH1} state_t;
  state_t                        state_q;
  logic [23:0]                   mem [FIFO_DEPTH];
  logic [PW-1:0]                 wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0]                 level_q, level_d;
  logic                          tready_q;
  logic [DIV_WIDTH-1:0]          cnt_q, cnt_d;
  logic                          tick, push, pop, empty, idle;
  logic                          awvalid_q, wvalid_q, bready_q;
  logic [C_M_AXI_ADDR_WIDTH-1:0] awaddr_q;
  logic [11:0]                   wdata_q, ch1_q;
  logic                          aw_ok, w_ok;
  logic                          underrun_q, underrun_d, overrun_q, overrun_d, resp_err_q, resp_err_d;
  logic                          unused_tdata;
  assign unused_tdata = ^{s_axis_tdata[31:28], s_axis_tdata[15:12]};
  always_comb begin
    idle       = state_q == IDLE;
    empty      = level_q == '0;
    tick       = enable && cnt_q == period;
    cnt_d      = (!enable || tick) ? '0 : cnt_q + 1'b1;
    push       = s_axis_tvalid && tready_q;
    pop        = tick && idle && !empty;
    wr_d       = push ? wr_q + 1'b1 : wr_q;
    rd_d       = pop ? rd_q + 1'b1 : rd_q;
    level_d    = level_q + LW'(push) - LW'(pop);
    aw_ok      = !awvalid_q || m_axi.awready;
    w_ok       = !wvalid_q || m_axi.wready;
    underrun_d = (tick && idle && empty) || (underrun_q && !clear_flags);
    overrun_d  = (tick && !idle) || (overrun_q && !clear_flags);
    resp_err_d = (bready_q && m_axi.bvalid && m_axi.bresp != 2'b00) || (resp_err_q && !clear_flags);
  end
  always_ff @(posedge s_axi_aclk)
    if (push) mem[wr_q] <= {s_axis_tdata[27:16], s_axis_tdata[11:0]};
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn)
    if (!s_axi_aresetn) begin
      wr_q       <= '0;
      rd_q       <= '0;
      level_q    <= '0;
      tready_q   <= 1'b0;
      cnt_q      <= '0;
      underrun_q <= 1'b0;
      overrun_q  <= 1'b0;
      resp_err_q <= 1'b0;
    end else begin
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      level_q    <= level_d;
      tready_q   <= level_d != FULL;
      cnt_q      <= cnt_d;
      underrun_q <= underrun_d;
      overrun_q  <= overrun_d;
      resp_err_q <= resp_err_d;
    end
  // aw and w complete independently; a valid that has dropped counts as done
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn)
    if (!s_axi_aresetn) begin
      state_q   <= IDLE;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      ch1_q     <= '0;
    end else begin
      case (state_q)
        IDLE: if (pop) begin
          state_q   <= WR_CH0;
          awvalid_q <= 1'b1;
          wvalid_q  <= 1'b1;
          awaddr_q  <= ADDR_CH0;
          wdata_q   <= mem[rd_q][11:0];
          ch1_q     <= mem[rd_q][23:12];
        end
        WR_CH0, WR_CH1: if (aw_ok && w_ok) begin
          state_q   <= state_q == WR_CH0 ? RESP_CH0 : RESP_CH1;
          awvalid_q <= 1'b0;
          wvalid_q  <= 1'b0;
          bready_q  <= 1'b1;
        end else begin
          awvalid_q <= awvalid_q && !m_axi.awready;
          wvalid_q  <= wvalid_q && !m_axi.wready;
        end
        RESP_CH0, RESP_CH1: if (m_axi.bvalid) begin
          bready_q <= 1'b0;
          if (state_q == RESP_CH0 && DUAL_MODE != 0) begin
            state_q   <= WR_CH1;
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            awaddr_q  <= ADDR_CH1;
            wdata_q   <= ch1_q;
          end else
            state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  assign s_axis_tready = tready_q;
  assign fifo_level    = level_q;
  assign underrun      = underrun_q;
  assign overrun       = overrun_q;
  assign resp_err      = resp_err_q;
  assign m_axi.awaddr  = awaddr_q;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.awvalid = awvalid_q;
  assign m_axi.wdata   = {20'b0, wdata_q};
  assign m_axi.wstrb   = 4'hF;
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.bready  = bready_q;
endmodule
